// File: rtl/div_pkg.sv
// Shared types and default sizing for the shared-divider scheduler.
package div_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_ID_W  = $clog2(DEF_N_REQ);

    // Scheduler control states
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } state_t;

    // One response beat at the default sizing
    typedef struct packed {
        logic [DEF_ID_W-1:0]  id;
        logic [DEF_WIDTH-1:0] quot;
        logic [DEF_WIDTH-1:0] rem;
        logic                 dbz;
    } rsp_t;

endpackage

// File: rtl/div_sched_if.sv
// Request/response channels between the client FSMs and the divider scheduler.
interface div_sched_if
    import div_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) ();

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0][WIDTH-1:0] req_a;
    logic [N_REQ-1:0][WIDTH-1:0] req_b;

    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [ID_W-1:0]             rsp_id;
    logic [WIDTH-1:0]            rsp_quot;
    logic [WIDTH-1:0]            rsp_rem;
    logic                        rsp_dbz;

    // Client side: issues requests, consumes responses
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz
    );

endinterface

// File: rtl/div_core.sv
// Iterative unsigned restoring divider: one dividend bit per cycle, MSB first.
module div_core
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // quot_r starts as the dividend; each step consumes its MSB and
    // shifts a quotient bit into its LSB, so it ends holding the quotient.
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] div_r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shifted;
    logic             fits;

    // Trial partial remainder and compare for the current step
    always_comb begin
        shifted = {rem_r[WIDTH-2:0], quot_r[WIDTH-1]};
        fits    = (shifted >= div_r);
    end

    // Load on start, then WIDTH shift/subtract steps counted down
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_r  <= '0;
            quot_r <= '0;
            div_r  <= '0;
            cnt    <= '0;
        end else if (start) begin
            rem_r  <= '0;
            quot_r <= a;
            div_r  <= b;
            cnt    <= CNT_W'(WIDTH);
        end else if (cnt != '0) begin
            rem_r  <= fits ? (shifted - div_r) : shifted;
            quot_r <= {quot_r[WIDTH-2:0], fits};
            cnt    <= cnt - 1'b1;
        end
    end

    // High during the cycle whose closing edge performs the final step
    assign done = (cnt == CNT_W'(1));
    assign quot = quot_r;
    assign rem  = rem_r;

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one iterative divider among N_REQ requesters.
module div_sched
    import div_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic        clk,
    input  logic        reset,
    div_sched_if.slave  bus,
    output logic        busy
);

    state_t           state;
    logic [ID_W-1:0]  rr;
    logic [ID_W-1:0]  grant;
    logic             grant_vld;
    logic             hs;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    logic             rsp_valid_r;
    logic [ID_W-1:0]  id_r;
    logic             dbz_r;
    logic [WIDTH-1:0] dbz_rem_r;

    logic             core_start;
    logic             core_done;
    logic [WIDTH-1:0] core_quot;
    logic [WIDTH-1:0] core_rem;

    // First requesting index above the round-robin pointer, wrapping
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            int unsigned idx;
            idx = (int'(rr) + k) % N_REQ;
            if (!grant_vld && bus.req_valid[ID_W'(idx)]) begin
                grant     = ID_W'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    // Accept strobe only in IDLE, only for the granted requester
    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && grant_vld) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    assign hs         = (state == IDLE) && grant_vld;
    assign sel_a      = bus.req_a[grant];
    assign sel_b      = bus.req_b[grant];
    assign core_start = hs && (sel_b != '0);

    div_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .start (core_start),
        .a     (sel_a),
        .b     (sel_b),
        .done  (core_done),
        .quot  (core_quot),
        .rem   (core_rem)
    );

    // Control FSM: grant, run the core (or short-circuit divide-by-zero), hold response
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr          <= ID_W'(N_REQ - 1);
            rsp_valid_r <= 1'b0;
            id_r        <= '0;
            dbz_r       <= 1'b0;
            dbz_rem_r   <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        rr   <= grant;
                        id_r <= grant;
                        busy <= 1'b1;
                        if (sel_b == '0) begin
                            dbz_r       <= 1'b1;
                            dbz_rem_r   <= sel_a;
                            rsp_valid_r <= 1'b1;
                            state       <= RESP;
                        end else begin
                            dbz_r <= 1'b0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (core_done) begin
                        rsp_valid_r <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The core holds its final quotient/remainder until the next start,
    // so the response reads them directly; divide-by-zero uses local copies.
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = id_r;
    assign bus.rsp_dbz   = dbz_r;
    assign bus.rsp_quot  = dbz_r ? '1 : core_quot;
    assign bus.rsp_rem   = dbz_r ? dbz_rem_r : core_rem;

endmodule

// File: tb/tb_div_sched.sv
// Testbench for div_sched: vector table, scoreboard monitor and corner sequences.
module tb_div_sched;
    import div_pkg::*;

    localparam int unsigned N = DEF_N_REQ;
    localparam int unsigned W = DEF_WIDTH;

    typedef logic [DEF_ID_W-1:0] id_t;
    typedef logic [W-1:0]        word_t;

    typedef struct {
        id_t   id;
        word_t a;
        word_t b;
        word_t quot;
        word_t rem;
        logic  dbz;
        int    lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;

    div_sched_if #(.N_REQ(N), .WIDTH(W)) bus ();

    div_sched #(.N_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t model_rsp(input id_t id, input word_t a, input word_t b);
        rsp_t r;
        r.id = id;
        if (b == '0) begin
            r.quot = '1;
            r.rem  = a;
            r.dbz  = 1'b1;
        end else begin
            r.quot = a / b;
            r.rem  = a % b;
            r.dbz  = 1'b0;
        end
        return r;
    endfunction

    function automatic int model_grant(input logic [N-1:0] v, input int rr);
        for (int k = 1; k <= int'(N); k++) begin
            int idx;
            idx = (rr + k) % int'(N);
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // ---------------- scoreboard monitor ----------------
    rsp_t sb[$];
    int   acc_q[$];
    int   lat_q[$];
    int   grant_log[$];
    int   cycle = 0;
    int   m_rr = int'(N) - 1;
    bit   m_busy = 1'b0;
    bit   prev_valid = 1'b0;

    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_ready;
        rsp_t e;
        cycle++;
        if (reset) begin
            sb.delete();
            acc_q.delete();
            lat_q.delete();
            m_busy     = 1'b0;
            m_rr       = int'(N) - 1;
            prev_valid = 1'b0;
        end else begin
            g = model_grant(bus.req_valid, m_rr);
            exp_ready = '0;
            if (!m_busy && g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", bus.req_ready, exp_ready);
            chk("busy", busy, m_busy);
            if (bus.rsp_valid) begin
                chk("rsp_pending", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb[0];
                    chk("sb_id", bus.rsp_id, e.id);
                    chk("sb_quot", bus.rsp_quot, e.quot);
                    chk("sb_rem", bus.rsp_rem, e.rem);
                    chk("sb_dbz", bus.rsp_dbz, e.dbz);
                    if (!prev_valid) chk("sb_latency", cycle - acc_q[0], lat_q[0]);
                    if (bus.rsp_ready) begin
                        void'(sb.pop_front());
                        void'(acc_q.pop_front());
                        void'(lat_q.pop_front());
                        m_busy = 1'b0;
                    end
                end
            end
            prev_valid = bus.rsp_valid && !bus.rsp_ready;
            for (int i = 0; i < int'(N); i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    sb.push_back(model_rsp(id_t'(i), bus.req_a[i], bus.req_b[i]));
                    acc_q.push_back(cycle);
                    lat_q.push_back((bus.req_b[i] == '0) ? 1 : int'(W) + 1);
                    grant_log.push_back(i);
                    m_busy = 1'b1;
                    m_rr   = i;
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic do_req(input id_t id, input word_t a, input word_t b);
        bit hs;
        hs = 1'b0;
        bus.req_a[id]     = a;
        bus.req_b[id]     = b;
        bus.req_valid[id] = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (bus.req_ready[id]) begin
                hs = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
        chk("req_accept", hs, 1);
    endtask

    task automatic wait_rsp(output rsp_t got, output int lat);
        got = '0;
        lat = -1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = {bus.rsp_id, bus.rsp_quot, bus.rsp_rem, bus.rsp_dbz};
                lat = c + 1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[8];
    int   exp_order_a[5];
    int   exp_order_b[2];

    initial begin
        rsp_t got;
        int   lat;
        int   seen;

        vecs[0] = '{id: 0, a: 100, b: 7,   quot: 14,  rem: 2,   dbz: 0, lat: 9};
        vecs[1] = '{id: 2, a: 255, b: 1,   quot: 255, rem: 0,   dbz: 0, lat: 9};
        vecs[2] = '{id: 1, a: 5,   b: 9,   quot: 0,   rem: 5,   dbz: 0, lat: 9};
        vecs[3] = '{id: 3, a: 200, b: 0,   quot: 255, rem: 200, dbz: 1, lat: 1};
        vecs[4] = '{id: 1, a: 0,   b: 5,   quot: 0,   rem: 0,   dbz: 0, lat: 9};
        vecs[5] = '{id: 2, a: 255, b: 255, quot: 1,   rem: 0,   dbz: 0, lat: 9};
        vecs[6] = '{id: 0, a: 0,   b: 0,   quot: 255, rem: 0,   dbz: 1, lat: 1};
        vecs[7] = '{id: 3, a: 254, b: 255, quot: 0,   rem: 254, dbz: 0, lat: 9};
        exp_order_a = '{0, 1, 2, 3, 0};
        exp_order_b = '{2, 0};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_quot", bus.rsp_quot, 0);
        chk("rst_rem", bus.rsp_rem, 0);
        chk("rst_dbz", bus.rsp_dbz, 0);
        @(posedge clk); #1;

        // Table-driven single transactions
        for (int i = 0; i < 8; i++) begin
            do_req(vecs[i].id, vecs[i].a, vecs[i].b);
            wait_rsp(got, lat);
            chk("vec_id", got.id, vecs[i].id);
            chk("vec_quot", got.quot, vecs[i].quot);
            chk("vec_rem", got.rem, vecs[i].rem);
            chk("vec_dbz", got.dbz, vecs[i].dbz);
            chk("vec_latency", lat, vecs[i].lat);
        end
        wait_idle();

        // Round-robin order with all requesters held valid from reset
        pulse_reset();
        grant_log.delete();
        for (int i = 0; i < int'(N); i++) begin
            bus.req_a[i] = word_t'(50 + 17 * i);
            bus.req_b[i] = word_t'(3 + i);
        end
        bus.req_valid = '1;
        for (int c = 0; c < 200 && grant_log.size() < 5; c++) begin
            @(posedge clk); #1;
        end
        bus.req_valid = '0;
        wait_idle();
        chk("order_a_len", grant_log.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < grant_log.size()) chk("order_a", grant_log[k], exp_order_a[k]);

        // Only requesters 0 and 2 with the pointer at 0
        grant_log.delete();
        bus.req_valid = 4'b0101;
        for (int c = 0; c < 200 && grant_log.size() < 2; c++) begin
            @(posedge clk); #1;
            foreach (grant_log[k]) bus.req_valid[id_t'(grant_log[k])] = 1'b0;
        end
        bus.req_valid = '0;
        wait_idle();
        chk("order_b_len", grant_log.size(), 2);
        for (int k = 0; k < 2; k++)
            if (k < grant_log.size()) chk("order_b", grant_log[k], exp_order_b[k]);

        // Backpressure: response held, no acceptance, then regrant next cycle
        bus.rsp_ready = 1'b0;
        do_req(1, 77, 6);
        bus.req_a[3] = 9;
        bus.req_b[3] = 2;
        bus.req_valid[3] = 1'b1;
        seen = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1;
                break;
            end
        end
        chk("bp_valid_seen", seen, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_req_ready", bus.req_ready, 0);
            chk("bp_id", bus.rsp_id, 1);
            chk("bp_quot", bus.rsp_quot, 12);
            chk("bp_rem", bus.rsp_rem, 5);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_req_ready", bus.req_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_regrant", bus.req_ready, 4'b1000);
        chk("bp_valid_low", bus.rsp_valid, 0);
        @(posedge clk); #1;
        bus.req_valid[3] = 1'b0;
        wait_idle();

        // Reset during the 4th RUN cycle abandons the operation
        do_req(2, 150, 7);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_valid", bus.rsp_valid, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        chk("abort_no_rsp", seen, 0);
        @(posedge clk); #1;
        bus.req_a[0] = 30;
        bus.req_b[0] = 4;
        bus.req_a[3] = 40;
        bus.req_b[3] = 3;
        bus.req_valid[0] = 1'b1;
        bus.req_valid[3] = 1'b1;
        @(negedge clk);
        chk("rr_after_reset", bus.req_ready, 4'b0001);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (bus.req_ready[3]) break;
        end
        @(posedge clk); #1;
        bus.req_valid[3] = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
